// File: rtl/eth_frame_checker_pkg.sv
// Shared types for the Ethernet frame checker: FSM encoding, length width and per-frame result.
package eth_chk_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_FRAME = 2'd1,
    ST_DROP     = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic             ok;
    logic [LEN_W-1:0] len;
    logic             err_pattern;
    logic             err_len;
    logic             err_user;
  } frame_result_t;

  // Length counter step that sticks at all-ones instead of wrapping.
  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
    if (v == {LEN_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(LEN_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/eth_frame_checker_if.sv
// AXI-Stream style receive byte stream from the MAC (no backpressure).
interface eth_frame_checker_if;
  logic [7:0] rx_axis_tdata;
  logic       rx_axis_tvalid;
  logic       rx_axis_tlast;
  logic       rx_axis_tuser;

  modport master (output rx_axis_tdata, output rx_axis_tvalid, output rx_axis_tlast, output rx_axis_tuser);
  modport slave  (input  rx_axis_tdata, input  rx_axis_tvalid, input  rx_axis_tlast, input  rx_axis_tuser);
endinterface

// File: rtl/eth_frame_checker_sat_counter.sv
// Statistics counter that saturates at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment or hold
  always_comb begin
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_frame_checker.sv
// Ethernet RX frame checker: incrementing-byte pattern, length and tuser checks with statistics.
// Optional ETH_FRAME_CHECKER_CONTINUITY_EN also checks each frame's first byte against the previous frame.
module eth_frame_checker
  import eth_chk_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1514,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  eth_frame_checker_if.slave rx,
  output logic               frame_done,
  output logic               frame_ok,
  output logic [LEN_W-1:0]   last_len,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   bad_cnt,
  output logic               err_pattern,
  output logic               err_len,
  output logic               err_user
);

  localparam logic [1:0]       S_IDLE     = 2'(ST_IDLE);
  localparam logic [1:0]       S_IN_FRAME = 2'(ST_IN_FRAME);
  localparam logic [1:0]       S_DROP     = 2'(ST_DROP);
  localparam logic [LEN_W-1:0] MIN_L      = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L      = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DROP_AT    = LEN_W'(MAX_LEN + 1);

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;
  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_next_s;
  logic [7:0]       exp_q, exp_d;
  logic             pat_err_q, pat_err_d;
  logic             first_s, mismatch_s, done_s;
  logic [2:0]       sticky_q, sticky_d;
  logic             done_q;
  frame_result_t    res_s, result_q;
`ifdef ETH_FRAME_CHECKER_CONTINUITY_EN
  logic             have_prev_q, have_prev_d;
`endif

  // Reset synchroniser: assert immediately, release two clocks later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Beat evaluation, frame result and FSM next state
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    exp_d      = exp_q;
    pat_err_d  = pat_err_q;
    first_s    = (state_q == S_IDLE);
    len_next_s = first_s ? {{(LEN_W-1){1'b0}}, 1'b1} : len_sat_inc(len_q);
    done_s     = rx.rx_axis_tvalid & rx.rx_axis_tlast;
`ifdef ETH_FRAME_CHECKER_CONTINUITY_EN
    if (first_s) begin
      mismatch_s = have_prev_q && (rx.rx_axis_tdata != exp_q);
    end else begin
      mismatch_s = (rx.rx_axis_tdata != exp_q);
    end
`else
    mismatch_s = !first_s && (rx.rx_axis_tdata != exp_q);
`endif
    res_s.err_pattern = pat_err_q | mismatch_s;
    res_s.err_len     = (len_next_s < MIN_L) || (len_next_s > MAX_L);
    res_s.err_user    = rx.rx_axis_tuser;
    res_s.len         = len_next_s;
    res_s.ok          = ~(res_s.err_pattern | res_s.err_len | res_s.err_user);

    if (rx.rx_axis_tvalid) begin
      exp_d = rx.rx_axis_tdata + 8'd1;
      if (rx.rx_axis_tlast) begin
        state_d   = S_IDLE;
        len_d     = '0;
        pat_err_d = 1'b0;
      end else begin
        len_d     = len_next_s;
        pat_err_d = pat_err_q | mismatch_s;
        case (state_q)
          S_IDLE:     state_d = S_IN_FRAME;
          S_IN_FRAME: begin
            if (len_next_s == DROP_AT) begin
              state_d = S_DROP;
            end else begin
              state_d = S_IN_FRAME;
            end
          end
          S_DROP:     state_d = S_DROP;
          default:    state_d = S_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end

    if (clear) begin
      sticky_d = 3'b000;
    end else if (done_s) begin
      sticky_d = sticky_q | {res_s.err_pattern, res_s.err_len, res_s.err_user};
    end else begin
      sticky_d = sticky_q;
    end
  end

`ifdef ETH_FRAME_CHECKER_CONTINUITY_EN
  // A clear restarts continuity, so the next frame after it takes a free seed
  always_comb begin
    if (clear) begin
      have_prev_d = 1'b0;
    end else if (done_s) begin
      have_prev_d = 1'b1;
    end else begin
      have_prev_d = have_prev_q;
    end
  end

  // Continuity history register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      have_prev_q <= 1'b0;
    end else begin
      have_prev_q <= have_prev_d;
    end
  end
`endif

  // Frame tracking state
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      exp_q     <= 8'd0;
      pat_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      exp_q     <= exp_d;
      pat_err_q <= pat_err_d;
    end
  end

  // Registered per-frame result and sticky error flags
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      done_q   <= 1'b0;
      result_q <= '0;
      sticky_q <= 3'b000;
    end else begin
      done_q   <= done_s;
      sticky_q <= sticky_d;
      if (done_s) begin
        result_q <= res_s;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_frame_cnt (
    .clk(clk), .rst_n(rst_int_n), .clear_i(clear), .inc_i(done_s), .cnt_o(frame_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_good_cnt (
    .clk(clk), .rst_n(rst_int_n), .clear_i(clear), .inc_i(done_s & res_s.ok), .cnt_o(good_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bad_cnt (
    .clk(clk), .rst_n(rst_int_n), .clear_i(clear), .inc_i(done_s & ~res_s.ok), .cnt_o(bad_cnt)
  );

  assign frame_done  = done_q;
  assign frame_ok    = result_q.ok;
  assign last_len    = result_q.len;
  assign err_pattern = sticky_q[2];
  assign err_len     = sticky_q[1];
  assign err_user    = sticky_q[0];

endmodule

// File: doc/eth_frame_checker.md
ETH_FRAME_CHECKER -- requirements
Module: eth_frame_checker

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal frame length in bytes (FCS excluded).
REQ-002 Parameter MAX_LEN, default 1514, maximum legal frame length in bytes (FCS excluded).
REQ-003 Parameter CNT_W, default 32, width of every statistics counter.
REQ-004 One clock; reset is asynchronous and active-low: clk  input  1  sole clock, rising edge (MAC rx_clk domain).
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 clear  input  1  synchronous counter/flag clear, active high.
REQ-007 rx_axis_tdata  input  8  received byte from MAC.
REQ-008 rx_axis_tvalid  input  1  byte valid; no backpressure, block always accepts.
REQ-009 rx_axis_tlast  input  1  last byte of frame.
REQ-010 rx_axis_tuser  input  1  frame bad (qualified with tvalid&tlast).
REQ-011 frame_done  output  1  one-cycle pulse per completed frame.
REQ-012 frame_ok  output  1  result of frame just completed, valid with frame_done.
REQ-013 last_len  output  16  byte length of frame just completed.
REQ-014 frame_cnt / good_cnt / bad_cnt  output  CNT_W each  total, good, bad frames.
REQ-015 err_pattern / err_len / err_user  output  1 each  sticky error flags.

Function
REQ-016 Beat = cycle with rx_axis_tvalid=1; non-valid cycles change no state.
REQ-017 FSM states IDLE, IN_FRAME, DROP; IDLE->IN_FRAME on non-last beat; IDLE->IDLE on single-beat frame (tlast on first beat, completed at once).
REQ-018 IN_FRAME->IDLE on beat with tlast; IN_FRAME->DROP when byte count reaches MAX_LEN+1 without tlast; DROP->IDLE on tlast beat.
REQ-019 Expected pattern: byte n+1 = (byte n + 1) mod 256 within a frame; 0xFF->0x00 wrap is legal.
REQ-020 First byte of a frame is the seed and is not pattern-checked (unless REQ-034 applies).
REQ-021 Length counter counts beats per frame, saturates at 0xFFFF.
REQ-022 Frame is bad if any pattern mismatch, length < MIN_LEN, length > MAX_LEN, or tuser=1 on tlast beat.
REQ-023 frame_done, frame_ok, last_len update on the cycle after the tlast beat (latency 1).
REQ-024 frame_cnt increments with every frame_done; exactly one of good_cnt/bad_cnt increments with it.
REQ-025 Counters saturate at all-ones; no wrap.
REQ-026 Sticky flags set at frame completion by cause, held until clear or reset.
REQ-027 clear zeroes counters and sticky flags next cycle; frame in progress continues and is counted.
REQ-028 clear coincident with frame_done increment: clear wins, counters read 0.
REQ-029 Oversized frame (DROP) completes as one bad frame with err_len, last_len saturated value.

Reset
REQ-030 rst_n low: FSM=IDLE, all counters 0, flags 0, frame_done 0, frame_ok 0, last_len 0, expected-byte register 0.
REQ-031 Reset mid-frame aborts it uncounted; remaining beats after rst_n release until tlast are treated as a new frame.
REQ-032 rst_n deassertion is synchronised internally (async assert, sync release).

Configuration
REQ-033 Macro ETH_FRAME_CHECKER_CONTINUITY_EN selects inter-frame continuity checking.
REQ-034 Defined: first byte of each frame except first after reset/clear must equal last byte of previous frame + 1 mod 256; mismatch flags pattern error.
REQ-035 Undefined: every frame's first byte is a free seed; no state carried between frames.

Structure
REQ-036 Package eth_chk_pkg holds FSM state enum, LEN_W=16 constant, and result struct (ok, len, error causes).
REQ-037 Sub-module sat_counter (parameter width; inc, clear, saturating) instantiated for frame_cnt, good_cnt, bad_cnt.

Verification
REQ-038 256-beat frame 0x00..0xFF, tlast on 0xFF, tuser 0 -> frame_done 1 cycle later, frame_ok=1, last_len=256, good_cnt=1.
REQ-039 Same frame with byte 100 = 0x65 instead of 0x64 -> frame_ok=0, err_pattern=1, bad_cnt=1.
REQ-040 40-byte frame -> err_len=1, last_len=40; 1600-beat frame -> DROP, one bad frame, err_len=1.
REQ-041 Valid 64-byte frame with tuser=1 on tlast -> err_user=1, bad_cnt=1; tvalid gaps in any frame -> identical results.
REQ-042 rst_n low at beat 50 of frame -> all counters 0; clear with frame_done same cycle -> counters 0.
REQ-043 CONTINUITY_EN: frames 0x00..0xFF then 0x00..0xFF -> both good; second frame starting 0x05 -> bad, err_pattern=1; without macro -> good.
